// File: rtl/card_deal_ctl.sv
// Dealing sequencer: fills a pair table, Fisher-Yates shuffles it with an LFSR,
// then streams it to the register file as packed {data, address, enable} writes.
module card_deal_ctl #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 14,
    parameter int STATE_W   = 2,
    parameter int MAX_CARDS = 32,
    parameter int FIRST_IDX = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W:0]          num_of_cards,
    input  logic                     wr_ready,
    output logic [DATA_W+ADDR_W:0]   write_data,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_SHUFFLE, S_WRITE, S_DONE} state_t;

    state_t            state;
    logic [15:0]       lfsr;
    logic [ADDR_W-1:0] tab [MAX_CARDS];
    logic [ADDR_W:0]   n;
    logic [ADDR_W-1:0] k;
    logic [ADDR_W-1:0] i;
    logic [ADDR_W-1:0] last;
    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] j;
    logic [ADDR_W:0]   n_req;
    logic [ADDR_W:0]   end_addr;
    logic              req_bad;

    function automatic logic [DATA_W+ADDR_W:0] pack(input logic [ADDR_W-1:0] pid,
                                                     input logic [ADDR_W-1:0] idx);
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        data = '0;
        data[STATE_W +: ADDR_W] = pid;
        addr = idx + ADDR_W'(FIRST_IDX);
        return {data, addr, 1'b1};
    endfunction

    always_comb begin
        n_req    = num_of_cards & ~(ADDR_W+1)'(1);
        end_addr = n_req + (ADDR_W+1)'(FIRST_IDX) - (ADDR_W+1)'(1);
        req_bad  = (n_req < (ADDR_W+1)'(2)) || (32'(n_req) > 32'(MAX_CARDS)) ||
                   (end_addr > (ADDR_W+1)'(2**ADDR_W - 1));
        last     = ADDR_W'(n - 1);
        mask     = i;
        for (int unsigned s = 1; s < ADDR_W; s++) begin
            mask = mask | (mask >> s);
        end
        j = lfsr[ADDR_W-1:0] & mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            write_data <= '0;
            err        <= 1'b0;
            n          <= '0;
            k          <= '0;
            i          <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (req_bad) begin
                            err   <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            err   <= 1'b0;
                            n     <= n_req;
                            k     <= '0;
                            state <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    tab[k] <= {1'b0, k[ADDR_W-1:1]};
                    if (k == last) begin
                        i     <= last;
                        state <= S_SHUFFLE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                S_SHUFFLE: begin
                    if (j <= i) begin
                        tab[i] <= tab[j];
                        tab[j] <= tab[i];
                        i      <= i - 1'b1;
                        if (i == ADDR_W'(1)) begin
                            // Final swap lands this cycle; forward its effect on entry 0.
                            k          <= '0;
                            write_data <= pack((j == '0) ? tab[1] : tab[0], '0);
                            state      <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (wr_ready) begin
                        if (k == last) begin
                            write_data <= '0;
                            state      <= S_DONE;
                        end else begin
                            k          <= k + 1'b1;
                            write_data <= pack(tab[k + 1'b1], k + 1'b1);
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_card_deal_ctl.sv
// Directed bench for card_deal_ctl: layout validity, rejects, backpressure,
// shuffle variation, mid-write reset and start-while-busy.
module tb_card_deal_ctl;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 14;
    localparam int STATE_W   = 2;
    localparam int MAX_CARDS = 32;
    localparam int FIRST_IDX = 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [ADDR_W:0]        num_of_cards;
    logic                   wr_ready;
    logic [DATA_W+ADDR_W:0] write_data;
    logic                   busy;
    logic                   done;
    logic                   err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [ADDR_W-1:0] got_addr [$];
    logic [DATA_W-1:0] got_data [$];
    int                done_cnt;
    int                bp_mode;
    int                bp_idx;
    bit                pat [7] = '{1, 0, 0, 1, 0, 1, 1};
    logic              prev_stall;
    logic [DATA_W+ADDR_W:0] prev_wd;
    int                lay1 [30];
    int                lay2 [30];

    always #5 clk = ~clk;

    card_deal_ctl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STATE_W(STATE_W),
        .MAX_CARDS(MAX_CARDS), .FIRST_IDX(FIRST_IDX)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_of_cards(num_of_cards),
        .wr_ready(wr_ready), .write_data(write_data), .busy(busy),
        .done(done), .err(err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: hold check, drive wr_ready, log accepted writes, advance past the edge.
    task automatic tick();
        if (prev_stall) check("hold", write_data, prev_wd);
        if (write_data[0]) begin
            wr_ready = (bp_mode != 0) ? pat[bp_idx % 7] : 1'b1;
            bp_idx++;
        end else begin
            wr_ready = 1'b1;
        end
        if (write_data[0] && wr_ready && !rst) begin
            got_addr.push_back(write_data[ADDR_W:1]);
            got_data.push_back(write_data[DATA_W+ADDR_W:ADDR_W+1]);
        end
        if (done) done_cnt++;
        prev_stall = write_data[0] && !wr_ready && !rst;
        prev_wd    = write_data;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; wr_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        prev_stall = 1'b0;
    endtask

    task automatic deal(input string tag, input logic [ADDR_W:0] cnt, input int bp,
                        input int mid_start, input logic exp_err);
        got_addr.delete(); got_data.delete();
        done_cnt = 0; bp_mode = bp; bp_idx = 0;
        num_of_cards = cnt; start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy1"}, busy, 1);
        for (int c = 0; c < 4000 && done_cnt == 0; c++) begin
            if (c == mid_start) begin
                start = 1'b1; num_of_cards = 4;
            end
            tick();
            start = 1'b0;
        end
        check({tag, "_done_seen"}, done_cnt, 1);
        repeat (3) tick();
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_err"}, err, exp_err);
    endtask

    task automatic check_layout(input string tag, input int n);
        int bad_addr = 0, bad_state = 0, bad_pair = 0, id;
        int hist [32];
        check({tag, "_count"}, got_addr.size(), n);
        foreach (hist[h]) hist[h] = 0;
        foreach (got_addr[w]) begin
            if (got_addr[w] != ADDR_W'(FIRST_IDX + w)) bad_addr++;
            if (got_data[w][STATE_W-1:0] != '0) bad_state++;
            id = int'(got_data[w] >> STATE_W);
            if (id >= n / 2) bad_pair++;
            else hist[id]++;
        end
        for (int p = 0; p < n / 2; p++) if (hist[p] != 2) bad_pair++;
        check({tag, "_addr"}, bad_addr, 0);
        check({tag, "_state"}, bad_state, 0);
        check({tag, "_pairs"}, bad_pair, 0);
    endtask

    initial begin
        int differ, sorted1, sorted2;
        rst = 1'b1; start = 1'b0; wr_ready = 1'b1; num_of_cards = '0;
        bp_mode = 0; bp_idx = 0; done_cnt = 0; prev_stall = 1'b0; prev_wd = '0;
        do_reset();
        check("rst_wd", write_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);

        deal("d16", 16, 0, -1, 1'b0);  check_layout("d16", 16);
        deal("d7", 7, 0, -1, 1'b0);    check_layout("d7", 6);
        deal("d1", 1, 0, -1, 1'b1);    check_layout("d1", 0);
        deal("d2", 2, 0, -1, 1'b0);    check_layout("d2", 2);
        deal("d32", 32, 0, -1, 1'b1);  check_layout("d32", 0);
        deal("d34", 34, 0, -1, 1'b1);  check_layout("d34", 0);
        deal("d0", 0, 0, -1, 1'b1);    check_layout("d0", 0);
        deal("d31", 31, 0, -1, 1'b0);  check_layout("d31", 30);

        deal("bp4", 4, 1, -1, 1'b0);   check_layout("bp4", 4);

        do_reset();
        repeat (3) tick();
        deal("rnd1", 30, 0, -1, 1'b0); check_layout("rnd1", 30);
        for (int w = 0; w < 30 && w < got_data.size(); w++) lay1[w] = int'(got_data[w] >> STATE_W);
        do_reset();
        repeat (11) tick();
        deal("rnd2", 30, 0, -1, 1'b0); check_layout("rnd2", 30);
        for (int w = 0; w < 30 && w < got_data.size(); w++) lay2[w] = int'(got_data[w] >> STATE_W);
        differ = 0; sorted1 = 1; sorted2 = 1;
        for (int w = 0; w < 30; w++) begin
            if (lay1[w] != lay2[w]) differ = 1;
            if (lay1[w] != w / 2) sorted1 = 0;
            if (lay2[w] != w / 2) sorted2 = 0;
        end
        check("rnd_differ", differ, 1);
        check("rnd1_shuffled", sorted1, 0);
        check("rnd2_shuffled", sorted2, 0);

        got_addr.delete(); got_data.delete();
        done_cnt = 0; bp_mode = 0; bp_idx = 0;
        num_of_cards = 8; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 500 && got_addr.size() < 3; c++) tick();
        check("mid_three", got_addr.size(), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_en", write_data[0], 0);
        check("mid_idle", busy, 0);
        repeat (5) tick();
        check("mid_no_done", done_cnt, 0);
        check("mid_writes", got_addr.size(), 3);
        deal("after_rst", 8, 0, -1, 1'b0); check_layout("after_rst", 8);

        deal("busy_start", 10, 0, 12, 1'b0); check_layout("busy_start", 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
